// File: rtl/switch_arb_pkg.sv
// Shared types for the N x M switch arbiter: per-output state and width helper.
package switch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFERED = 2'd1,
        LOCKED  = 2'd2
    } out_state_t;

    // Index width for a port count; never below 1 so a 2-port field still exists.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/switch_arbiter_nxm_if.sv
// Request/grant bundle between the arbiter and its N_IN inputs / N_OUT outputs.
interface switch_arbiter_nxm_if
    import switch_arb_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8
) ();
    localparam int IW = clog2(N_IN);
    localparam int OW = clog2(N_OUT);

    // Handshake: grant_valid[i] with grant_out field i presents output o to input i;
    // ack[o] high while that offer is presented completes it at the rising edge.
    // An offer may change or vanish on any edge where it was not acked.
    logic [N_IN*N_OUT-1:0] req;
    logic [N_OUT-1:0]      ack;
    logic [N_IN-1:0]       release_lock;
    logic [N_IN*OW-1:0]    grant_out;
    logic [N_IN-1:0]       grant_valid;
    logic [N_OUT-1:0]      out_busy;
    logic [2*N_OUT-1:0]    dbg_state;

    modport slave (
        input  req, ack, release_lock,
        output grant_out, grant_valid, out_busy, dbg_state
    );

    modport master (
        output req, ack, release_lock,
        input  grant_out, grant_valid, out_busy, dbg_state
    );
endinterface

// File: rtl/switch_arbiter_nxm_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, wrapping modulo N.
module rr_pick
    import switch_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);
    int         cand;
    logic [W-1:0] cand_w;

    // Scan farthest-first so the nearest candidate after ptr is written last.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        cand   = 0;
        cand_w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            cand_w = W'(cand);
            if (req[cand_w]) begin
                idx   = cand_w;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_arbiter_nxm.sv
// N x M crossbar arbiter: single-iteration grant/accept match with per-output
// IDLE/OFFERED/LOCKED state and packet locking of acked grants.
module switch_arbiter_nxm
    import switch_arb_pkg::*;
#(
    parameter int N_IN       = 8,
    parameter int N_OUT      = 8,
    parameter int BLOCK_SELF = 1,
    parameter int LOCK_EN    = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    switch_arbiter_nxm_if.slave bus
);
    localparam int IW        = clog2(N_IN);
    localparam int OW        = clog2(N_OUT);
    localparam bit SELF_MASK = (BLOCK_SELF != 0) && (N_IN == N_OUT);

    out_state_t  state [N_OUT];
    logic [IW-1:0] owner [N_OUT];
    logic [IW-1:0] g_ptr [N_OUT];
    logic [OW-1:0] a_ptr [N_IN];

    logic [N_OUT-1:0] out_acked;
    logic [N_IN-1:0]  in_acked;
    logic [N_IN-1:0]  in_locked;
    logic [N_IN-1:0]  col   [N_OUT];
    logic [N_OUT-1:0] offer [N_IN];
    logic [IW-1:0]    gidx  [N_OUT];
    logic [N_OUT-1:0] gv;
    logic [OW-1:0]    aidx  [N_IN];
    logic [N_IN-1:0]  av;
    logic [N_OUT-1:0] match_v;

    always_comb begin
        out_acked = '0;
        in_acked  = '0;
        in_locked = '0;
        for (int o = 0; o < N_OUT; o++) begin
            if (state[o] == OFFERED && bus.ack[o]) begin
                out_acked[o]     = 1'b1;
                in_acked[owner[o]] = 1'b1;
            end
            if (state[o] == LOCKED) in_locked[owner[o]] = 1'b1;
        end
    end

    // The pair being acked is withheld so a consumed grant rotates to the next requester.
    always_comb begin
        for (int o = 0; o < N_OUT; o++) begin
            col[o] = '0;
            for (int i = 0; i < N_IN; i++) begin
                col[o][i] = bus.req[i*N_OUT+o] && !in_locked[i] && (state[o] != LOCKED)
                            && !(SELF_MASK && i == o)
                            && !(out_acked[o] && owner[o] == IW'(i));
            end
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_grant
        rr_pick #(.N(N_IN)) u_pick (
            .req   (col[o]),
            .ptr   (g_ptr[o]),
            .idx   (gidx[o]),
            .valid (gv[o])
        );
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            offer[i] = '0;
            for (int o = 0; o < N_OUT; o++) begin
                offer[i][o] = gv[o] && (gidx[o] == IW'(i));
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_accept
        rr_pick #(.N(N_OUT)) u_pick (
            .req   (offer[i]),
            .ptr   (a_ptr[i]),
            .idx   (aidx[i]),
            .valid (av[i])
        );
    end

    always_comb begin
        match_v = '0;
        for (int o = 0; o < N_OUT; o++) begin
            match_v[o] = gv[o] && av[gidx[o]] && (aidx[gidx[o]] == OW'(o));
            if (LOCK_EN != 0 && (out_acked[o] || in_acked[gidx[o]])) match_v[o] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < N_OUT; o++) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                g_ptr[o] <= '0;
            end
            for (int i = 0; i < N_IN; i++) a_ptr[i] <= '0;
        end else begin
            for (int o = 0; o < N_OUT; o++) begin
                if (out_acked[o]) begin
                    g_ptr[o]        <= (owner[o] == IW'(N_IN - 1)) ? '0 : owner[o] + 1'b1;
                    a_ptr[owner[o]] <= (o == N_OUT - 1) ? '0 : OW'(o + 1);
                end
                if (state[o] == LOCKED) begin
                    if (bus.release_lock[owner[o]]) state[o] <= IDLE;
                end else if (LOCK_EN != 0 && out_acked[o]) begin
                    state[o] <= LOCKED;
                end else if (match_v[o]) begin
                    state[o] <= OFFERED;
                    owner[o] <= gidx[o];
                end else begin
                    state[o] <= IDLE;
                end
            end
        end
    end

    logic [N_IN*OW-1:0] gout;
    logic [N_IN-1:0]    gval;
    logic [N_OUT-1:0]   busy;
    logic [2*N_OUT-1:0] dbg;

    always_comb begin
        gout = '0;
        gval = '0;
        busy = '0;
        dbg  = '0;
        for (int o = 0; o < N_OUT; o++) begin
            dbg[2*o +: 2] = state[o];
            busy[o]       = (state[o] == LOCKED);
            if (state[o] != IDLE) begin
                gval[owner[o]]            = 1'b1;
                gout[owner[o]*OW +: OW]   = OW'(o);
            end
        end
    end

    assign bus.grant_out   = gout;
    assign bus.grant_valid = gval;
    assign bus.out_busy    = busy;
    assign bus.dbg_state   = dbg;
endmodule

// File: tb/tb_switch_arbiter_nxm.sv
// Directed bench for switch_arbiter_nxm: default, non-locking and 4x6 instances.
module tb_switch_arbiter_nxm;
  logic clock;
  logic reset_n;
  int   tests;
  int   fails;
  int   seq [6];

  switch_arbiter_nxm_if #(.N_IN(8), .N_OUT(8)) ia ();
  switch_arbiter_nxm_if #(.N_IN(8), .N_OUT(8)) ib ();
  switch_arbiter_nxm_if #(.N_IN(4), .N_OUT(6)) ic ();

  switch_arbiter_nxm #(.N_IN(8), .N_OUT(8), .BLOCK_SELF(1), .LOCK_EN(1)) u_a (
    .clock(clock), .reset_n(reset_n), .bus(ia));
  switch_arbiter_nxm #(.N_IN(8), .N_OUT(8), .BLOCK_SELF(1), .LOCK_EN(0)) u_b (
    .clock(clock), .reset_n(reset_n), .bus(ib));
  switch_arbiter_nxm #(.N_IN(4), .N_OUT(6), .BLOCK_SELF(1), .LOCK_EN(1)) u_c (
    .clock(clock), .reset_n(reset_n), .bus(ic));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    seq = '{1, 2, 4, 1, 2, 4};
    ia.req = '0; ia.ack = '0; ia.release_lock = '0;
    ib.req = '0; ib.ack = '0; ib.release_lock = '0;
    ic.req = '0; ic.ack = '0; ic.release_lock = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_gv", ia.grant_valid, 32'h0);
    check("rst_busy", ia.out_busy, 32'h0);
    check("rst_go", ia.grant_out, 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_gv", {ic.grant_valid, ib.grant_valid, ia.grant_valid}, 32'h0);
      check("idle_busy", {ic.out_busy, ib.out_busy, ia.out_busy}, 32'h0);
    end

    // input 3 -> output 5, lock, hold, release
    ia.req[3*8+5] = 1'b1;
    step();
    check("a_offer_gv", ia.grant_valid, 32'h08);
    check("a_offer_go3", ia.grant_out[9 +: 3], 32'd5);
    check("a_offer_state5", ia.dbg_state[10 +: 2], 32'd1);
    ia.ack[5] = 1'b1;
    step();
    ia.ack = '0;
    check("a_lock_busy", ia.out_busy, 32'h20);
    check("a_lock_gv", ia.grant_valid, 32'h08);
    ia.req = '0;
    step();
    check("a_hold_busy", ia.out_busy, 32'h20);
    check("a_hold_go3", ia.grant_out[9 +: 3], 32'd5);
    ia.release_lock[2] = 1'b1;
    ia.ack[1] = 1'b1;
    step();
    ia.release_lock = '0;
    ia.ack = '0;
    check("a_foreign_rel_busy", ia.out_busy, 32'h20);
    check("a_foreign_rel_gv", ia.grant_valid, 32'h08);
    ia.req[3*8+5] = 1'b1;
    ia.release_lock[3] = 1'b1;
    step();
    ia.release_lock = '0;
    check("a_rel_gv", ia.grant_valid, 32'h0);
    check("a_rel_busy", ia.out_busy, 32'h0);
    step();
    check("a_reoffer_gv", ia.grant_valid, 32'h08);
    check("a_reoffer_go3", ia.grant_out[9 +: 3], 32'd5);
    ia.req = '0;
    step();
    check("a_drop_gv", ia.grant_valid, 32'h0);

    // self request masked
    ia.req[4*8+4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("a_self_gv", ia.grant_valid, 32'h0);
    end
    ia.req = '0;

    // input 6 -> {2,3}, input 7 -> 3
    ia.req[6*8+2] = 1'b1;
    ia.req[6*8+3] = 1'b1;
    ia.req[7*8+3] = 1'b1;
    step();
    check("a_two_gv", ia.grant_valid, 32'h40);
    check("a_two_go6", ia.grant_out[18 +: 3], 32'd2);
    step();
    check("a_two_persist_gv", ia.grant_valid, 32'h40);
    check("a_two_persist_go6", ia.grant_out[18 +: 3], 32'd2);
    ia.ack[2] = 1'b1;
    step();
    ia.ack = '0;
    check("a_two_ack_busy", ia.out_busy, 32'h04);
    check("a_two_ack_gv", ia.grant_valid, 32'h40);
    step();
    check("a_two_i7_gv", ia.grant_valid, 32'hC0);
    check("a_two_i7_go", ia.grant_out[21 +: 3], 32'd3);
    ia.req = '0;
    ia.release_lock[6] = 1'b1;
    step();
    ia.release_lock = '0;
    check("a_two_end_gv", ia.grant_valid, 32'h0);
    check("a_two_end_busy", ia.out_busy, 32'h0);

    // non-locking rotation on output 0
    ib.req[1*8] = 1'b1;
    ib.req[2*8] = 1'b1;
    ib.req[4*8] = 1'b1;
    ib.ack[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("b_rot_gv", ib.grant_valid, 32'(1 << seq[k]));
      check("b_rot_go", ib.grant_out[seq[k]*3 +: 3], 32'd0);
      check("b_rot_busy", ib.out_busy, 32'h0);
    end
    ib.req = '0;
    ib.ack = '0;
    step();
    check("b_end_gv", ib.grant_valid, 32'h0);

    // 4x6 instance: pointer wrap modulo port count
    ic.req[2*6+5] = 1'b1;
    step();
    check("c_i2_gv", ic.grant_valid, 32'h4);
    check("c_i2_go", ic.grant_out[6 +: 3], 32'd5);
    ic.ack[5] = 1'b1;
    step();
    ic.ack = '0;
    check("c_i2_busy", ic.out_busy, 32'h20);
    ic.req = '0;
    ic.release_lock[2] = 1'b1;
    step();
    ic.release_lock = '0;
    check("c_i2_rel", ic.out_busy, 32'h0);
    ic.req[3*6+2] = 1'b1;
    step();
    check("c_i3o2_go", ic.grant_out[9 +: 3], 32'd2);
    ic.ack[2] = 1'b1;
    step();
    ic.ack = '0;
    check("c_i3o2_busy", ic.out_busy, 32'h04);
    ic.req = '0;
    ic.release_lock[3] = 1'b1;
    step();
    ic.release_lock = '0;
    ic.req[3*6+5] = 1'b1;
    step();
    check("c_i3o5_gv", ic.grant_valid, 32'h8);
    check("c_i3o5_go", ic.grant_out[9 +: 3], 32'd5);
    ic.ack[5] = 1'b1;
    step();
    ic.ack = '0;
    check("c_i3o5_busy", ic.out_busy, 32'h20);
    ic.req = '0;
    ic.release_lock[3] = 1'b1;
    step();
    ic.release_lock = '0;
    check("c_i3o5_rel", ic.out_busy, 32'h0);
    ic.req[0*6+5] = 1'b1;
    ic.req[3*6+5] = 1'b1;
    step();
    check("c_gptr_wrap_gv", ic.grant_valid, 32'h1);
    check("c_gptr_wrap_go", ic.grant_out[0 +: 3], 32'd5);
    ic.req = '0;
    step();
    ic.req[3*6+5] = 1'b1;
    ic.req[3*6+1] = 1'b1;
    step();
    check("c_aptr_wrap_go", ic.grant_out[9 +: 3], 32'd1);
    ic.req = '0;
    step();

    // release and ack together, then async reset while locked
    ia.req[0*8+2] = 1'b1;
    ia.req[1*8+4] = 1'b1;
    step();
    check("a_pair_gv", ia.grant_valid, 32'h03);
    check("a_pair_go0", ia.grant_out[0 +: 3], 32'd2);
    check("a_pair_go1", ia.grant_out[3 +: 3], 32'd4);
    ia.ack[2] = 1'b1;
    step();
    ia.ack = '0;
    check("a_pair_lock2", ia.out_busy, 32'h04);
    ia.release_lock[0] = 1'b1;
    ia.ack[4] = 1'b1;
    step();
    ia.release_lock = '0;
    ia.ack = '0;
    check("a_relack_busy", ia.out_busy, 32'h10);
    check("a_relack_gv", ia.grant_valid, 32'h02);
    step();
    check("a_relack_reoffer", ia.grant_valid, 32'h03);
    ia.ack[2] = 1'b1;
    step();
    ia.ack = '0;
    check("a_relock_busy", ia.out_busy, 32'h14);
    ia.req = '0;
    reset_n = 1'b0;
    #1;
    check("a_async_gv", ia.grant_valid, 32'h0);
    check("a_async_busy", ia.out_busy, 32'h0);
    check("a_async_go", ia.grant_out, 32'h0);
    #1 reset_n = 1'b1;
    ia.req[0*8+2] = 1'b1;
    ia.req[0*8+3] = 1'b1;
    ia.req[1*8+2] = 1'b1;
    step();
    check("a_ptr_reset_gv", ia.grant_valid, 32'h01);
    check("a_ptr_reset_go0", ia.grant_out[0 +: 3], 32'd2);
    ia.req = '0;
    step();
    check("a_final_gv", ia.grant_valid, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_arbiter_nxm.md
SWITCH_ARBITER_NXM -- requirements
Module: switch_arbiter_nxm

Interface
REQ-001 Parameter N_IN, default 8, number of input ports (2..32).
REQ-002 Parameter N_OUT, default 8, number of output ports (2..32).
REQ-003 Parameter BLOCK_SELF, default 1, masks req from input k to output k when 1; valid only when N_IN==N_OUT, otherwise it has no effect.
REQ-004 Parameter LOCK_EN, default 1, enables packet-mode locking of acknowledged grants.
REQ-005 Derived widths: OW=clog2(N_OUT), IW=clog2(N_IN).
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 req  in  N_IN*N_OUT  bit i*N_OUT+o = input i requests output o.
REQ-009 ack  in  N_OUT  ack[o] = output o accepts the grant currently presented for it.
REQ-010 release  in  N_IN  release[i] = input i ends its locked transfer.
REQ-011 grant_out  out  N_IN*OW  field i = output index granted to input i.
REQ-012 grant_valid  out  N_IN  grant_valid[i] = field i of grant_out is valid.
REQ-013 out_busy  out  N_OUT  out_busy[o] = output o is locked.

Function
REQ-014 Per-output state: IDLE (no grant), OFFERED (grant registered, awaiting ack), LOCKED (acked, held until release).
REQ-015 Each cycle a single-iteration two-phase match is computed combinationally over free outputs (IDLE/OFFERED) and free inputs (not owning a LOCKED output).
REQ-016 Grant phase: each free output picks one requesting free input, round-robin from g_ptr[o].
REQ-017 Accept phase: each input offered one or more grants accepts one, round-robin from a_ptr[i].
REQ-018 Accepted pairs are registered at the next edge. The output goes to OFFERED with grant_valid[i]=1 and grant_out[i]=o. Latency is 1 cycle from req to grant_valid.
REQ-019 OFFERED with ack[o]=0: at the edge the pair is replaced by the newly computed match, which may be the same pair.
REQ-020 OFFERED with ack[o]=1 and LOCK_EN=1: output goes to LOCKED at the edge and out_busy[o]=1. Any new match at that edge involving the same input or output is discarded.
REQ-021 OFFERED with ack[o]=1 and LOCK_EN=0: the grant is consumed and the output re-arbitrates normally. LOCKED is never entered.
REQ-022 Pointer update on an acked pair (i,o) only: g_ptr[o] <= (i+1) mod N_IN and a_ptr[i] <= (o+1) mod N_OUT. Unacked offers leave pointers unchanged.
REQ-023 Wrap-around is modulo the port count, not modulo 2^width, for non-power-of-two N.
REQ-024 LOCKED holds grant_out and grant_valid regardless of req. release[i] from the owner returns the output to IDLE at the edge.
REQ-025 After a release, grant_valid[i] is 0 for at least one cycle, because the freed output re-enters the match only after the edge.
REQ-026 release[i] is ignored when input i owns no LOCKED output. Ack on an IDLE output is ignored.
REQ-027 Release and ack in the same cycle on different outputs are both honoured.
REQ-028 Every output grants at most one input and every input holds at most one output in every cycle; no input is ever double-granted.
REQ-029 Self-request bits masked by BLOCK_SELF are never granted.

Reset
REQ-030 On reset_n=0, immediately and asynchronously: grant_valid=0, grant_out=0, out_busy=0, all outputs IDLE, all g_ptr/a_ptr=0.
REQ-031 First grant is possible at the first rising edge after reset_n deasserts. Deassertion is synchronised externally.
REQ-032 Reset mid-lock or mid-offer discards all state with no residual grant.

Structure
REQ-033 The shared package switch_arb_pkg holds the output-state enum (IDLE/OFFERED/LOCKED) and the clog2 helper function.
REQ-034 A sub-module rr_pick (parameter N; inputs req[N] and ptr; outputs idx and valid) is instantiated N_OUT times for the grant phase and N_IN times for the accept phase.

Verification
REQ-035 Reset with req=0 for 20 cycles -> grant_valid=0 and out_busy=0 throughout.
REQ-036 Default parameters, req input3->output5: next cycle grant_valid[3]=1 and grant_out[3]=5. Ack[5] -> out_busy[5]=1, held after req drops. release[3] -> grant_valid[3]=0 next cycle.
REQ-037 LOCK_EN=0; inputs 1, 2 and 4 hold req to output 0; ack every cycle -> grant sequence 1,2,4,1,2,4.
REQ-038 Input 6 requests outputs 2 and 3, input 7 requests output 3, pointers at 0, no ack -> grant_out[6]=2 and grant_valid[7]=0. This persists until an ack arrives.
REQ-039 BLOCK_SELF=1: input 4 requests only output 4 -> never granted. N_IN=4, N_OUT=6 instance: input 3->output 5 granted, and a second ack wraps g_ptr[5] to 0.
REQ-040 reset_n pulsed low while output 2 is LOCKED to input 0 -> grant_valid[0] and out_busy[2] drop without waiting for a clock edge. Pointers are 0 after reset.
